// File: rtl/conv2_map_feeder_if.sv
// Purpose : bundles the feeder's load-side and engine-side signals into one port.
// Latency : n/a (wiring only).
// Backpressure: wr_ready gates the load side; the engine side is valid-only and
//               is paced by the conv_complete pulse.
// master : the feeder itself (drives wr_ready, data_out*, busy, frame_done).
// slave  : the environment (previous layer + conv2 engine).
interface conv2_map_feeder_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] data_out;
    logic [1:0]            data_out_index;
    logic                  data_out_valid;
    logic                  conv_complete;
    logic                  busy;
    logic                  frame_done;

    modport master (
        input  wr_data, wr_valid, conv_complete,
        output wr_ready, data_out, data_out_index, data_out_valid, busy, frame_done
    );

    modport slave (
        output wr_data, wr_valid, conv_complete,
        input  wr_ready, data_out, data_out_index, data_out_valid, busy, frame_done
    );
endinterface

// File: rtl/conv2_map_feeder.sv
// Purpose : buffers NUM_MAPS pooled maps and streams them one channel at a time to conv2.
// Latency : first pixel appears one cycle after STREAM is entered (registered RAM read).
// Backpressure: wr_ready is high only in LOAD; streaming never stalls, channels advance on conv_complete.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   bus.wr_data/wr_valid/wr_ready raster-order pixel load, map 0 first
//   bus.data_out/_index/_valid    pixel stream to the conv2 engine
//   bus.conv_complete             one-cycle pulse from engine: current map finished
//   bus.busy                      high whenever the block is not in LOAD
//   bus.frame_done                one-cycle pulse after the last map completes
// Build option: define CONV2_FEED_ROW_GAP_EN to insert one idle cycle after every
//   row except the last row of each map.
module conv2_map_feeder #(
    parameter int DATA_WIDTH   = 8,
    parameter int DISP_WIDTH   = 13,
    parameter int NUM_MAPS     = 3,
    parameter int ADDR_WIDTH   = 10,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    conv2_map_feeder_if.master  bus
);

    localparam int MAP_PIX = DISP_WIDTH * DISP_WIDTH;
    localparam int TOTAL   = NUM_MAPS * MAP_PIX;
    localparam int RAM_AW  = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int CW      = (DISP_WIDTH > 1) ? $clog2(DISP_WIDTH) : 1;
    localparam int DCW     = $clog2(DRAIN_CYCLES + 1);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(TOTAL - 1);
    localparam logic [CW-1:0]         LAST_POS   = CW'(DISP_WIDTH - 1);
    localparam logic [DCW-1:0]        LAST_DRAIN = DCW'(DRAIN_CYCLES - 1);
    localparam logic [1:0]            LAST_MAP   = 2'(NUM_MAPS - 1);

    localparam logic [2:0] S_LOAD     = 3'd0;
    localparam logic [2:0] S_STREAM   = 3'd1;
    localparam logic [2:0] S_DRAIN    = 3'd2;
    localparam logic [2:0] S_WAIT_CPL = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic [DATA_WIDTH-1:0] mem [0:TOTAL-1];

    logic [2:0]            state_q,    state_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q,  wr_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q,  rd_addr_d;
    logic [1:0]            map_q,      map_d;
    logic [CW-1:0]         col_q,      col_d;
    logic [CW-1:0]         row_q,      row_d;
    logic [DCW-1:0]        drain_q,    drain_d;
    logic                  cpl_q,      cpl_d;
    logic                  gap_q,      gap_d;
    logic [DATA_WIDTH-1:0] dout_q,     dout_d;
    logic                  dout_vld_q, dout_vld_d;

    logic wr_en;
    logic rd_en;

    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        map_d      = map_q;
        col_d      = col_q;
        row_d      = row_q;
        drain_d    = drain_q;
        cpl_d      = cpl_q;
        gap_d      = gap_q;
        dout_d     = dout_q;
        dout_vld_d = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;

        // An early completion for the current map is remembered so WAIT_CPL
        // does not stall; repeated pulses simply keep the flag set.
        if (bus.conv_complete &&
            (state_q == S_STREAM || state_q == S_DRAIN || state_q == S_WAIT_CPL)) begin
            cpl_d = 1'b1;
        end

        case (state_q)
            S_LOAD: begin
                if (bus.wr_valid) begin
                    wr_en = 1'b1;
                    if (wr_addr_q == LAST_ADDR) begin
                        // Address holds at its final value until DONE rewinds it.
                        state_d   = S_STREAM;
                        map_d     = 2'd0;
                        rd_addr_d = '0;
                        col_d     = '0;
                        row_d     = '0;
                        gap_d     = 1'b0;
                        cpl_d     = 1'b0;
                    end else begin
                        wr_addr_d = wr_addr_q + 1'b1;
                    end
                end
            end

            S_STREAM: begin
                if (gap_q) begin
                    gap_d = 1'b0;
                end else begin
                    rd_en = 1'b1;
                    if (rd_addr_q != LAST_ADDR) begin
                        rd_addr_d = rd_addr_q + 1'b1;
                    end
                    if (col_q == LAST_POS) begin
                        col_d = '0;
                        if (row_q == LAST_POS) begin
                            row_d   = '0;
                            drain_d = '0;
                            state_d = S_DRAIN;
                        end else begin
                            row_d = row_q + 1'b1;
`ifdef CONV2_FEED_ROW_GAP_EN
                            gap_d = 1'b1;
`else
                            gap_d = 1'b0;
`endif
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end

            S_DRAIN: begin
                if (drain_q == LAST_DRAIN) begin
                    drain_d = '0;
                    state_d = S_WAIT_CPL;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end

            S_WAIT_CPL: begin
                if (cpl_q || bus.conv_complete) begin
                    cpl_d = 1'b0;
                    if (map_q == LAST_MAP) begin
                        state_d = S_DONE;
                    end else begin
                        map_d   = map_q + 1'b1;
                        state_d = S_STREAM;
                    end
                end
            end

            S_DONE: begin
                state_d   = S_LOAD;
                wr_addr_d = '0;
                map_d     = 2'd0;
                cpl_d     = 1'b0;
            end

            default: begin
                state_d = S_LOAD;
            end
        endcase

        // Read data and its qualifier land together one cycle after the read.
        if (rd_en) begin
            dout_d = mem[rd_addr_q[RAM_AW-1:0]];
        end
        dout_vld_d = rd_en;
    end

    // Buffer contents are never reset; every frame fully rewrites them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr_q[RAM_AW-1:0]] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_LOAD;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            map_q      <= 2'd0;
            col_q      <= '0;
            row_q      <= '0;
            drain_q    <= '0;
            cpl_q      <= 1'b0;
            gap_q      <= 1'b0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            map_q      <= map_d;
            col_q      <= col_d;
            row_q      <= row_d;
            drain_q    <= drain_d;
            cpl_q      <= cpl_d;
            gap_q      <= gap_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
        end
    end

    // The channel index is the map counter itself: it only moves on leaving
    // WAIT_CPL or DONE, so it is stable across valid data and the drain window.
    assign bus.wr_ready       = (state_q == S_LOAD);
    assign bus.busy           = (state_q != S_LOAD);
    assign bus.frame_done     = (state_q == S_DONE);
    assign bus.data_out       = dout_q;
    assign bus.data_out_valid = dout_vld_q;
    assign bus.data_out_index = map_q;

endmodule
